// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone interconnect: address map, FSM state type
// and index-width helper.
package wb_pkg;

  localparam int unsigned WB_NUM_SLAVES = 3;

  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK   = 32'hFFFF_FE00;
  localparam logic [31:0] SRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hFFFF_8000;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DECERR
  } wb_ic_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: priority-resolved one-hot match, binary hit
// index and a no_match flag. Lowest slave index wins on overlapping windows.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned                      NUM_SLAVES = WB_NUM_SLAVES,
  parameter int unsigned                      ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE   = {CLINT_BASE, SRAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK   = {CLINT_MASK, SRAM_MASK, ROM_MASK}
) (
  input  logic [ADDR_WIDTH-1:0]            adr,
  output logic [NUM_SLAVES-1:0]            match,
  output logic [idx_w(NUM_SLAVES)-1:0]     hit,
  output logic                             no_match
);

  localparam int unsigned IDX_W = idx_w(NUM_SLAVES);

  logic [NUM_SLAVES-1:0] raw;

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      raw[k] = ((adr & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_comb begin
    match    = '0;
    hit      = '0;
    no_match = 1'b1;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (raw[k] && no_match) begin
        match[k] = 1'b1;
        hit      = IDX_W'(k);
        no_match = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone B4 pipelined interconnect with registered slave
// select, stall forwarding, decode error and ack timeout. One outstanding transfer.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int unsigned                      NUM_SLAVES     = WB_NUM_SLAVES,
  parameter int unsigned                      ADDR_WIDTH     = 32,
  parameter int unsigned                      DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE       = {CLINT_BASE, SRAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK       = {CLINT_MASK, SRAM_MASK, ROM_MASK},
  parameter int unsigned                      TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic                             m_stall_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  input  logic [NUM_SLAVES-1:0]            s_stall_i
);

  localparam int unsigned IDX_W = idx_w(NUM_SLAVES);
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

  wb_ic_state_t          state, state_n;
  logic [IDX_W-1:0]      sel_q;
  logic [TW-1:0]         timer;
  logic [NUM_SLAVES-1:0] match;
  logic [IDX_W-1:0]      hit;
  logic                  no_match;
  logic                  accept;
  logic                  timeout;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .adr      (m_adr_i),
    .match    (match),
    .hit      (hit),
    .no_match (no_match)
  );

  assign s_we_o  = m_we_i;
  assign s_sel_o = m_sel_i;
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;

  assign timeout = (TIMEOUT_CYCLES != 0) && (timer == TO_VAL);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    m_dat_o   = '0;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_stall_o = 1'b1;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          m_stall_o = no_match ? 1'b0 : s_stall_i[hit];
          s_cyc_o   = m_cyc_i ? match : '0;
          s_stb_o   = m_stb_i ? match : '0;
          accept    = m_cyc_i & m_stb_i & !m_stall_o;
          if (accept) state_n = no_match ? ST_DECERR : ST_BUSY;
        end
        ST_BUSY: begin
          m_dat_o = s_dat_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
          if (!m_cyc_i) begin
            state_n = ST_IDLE;
          end else begin
            s_cyc_o[sel_q] = 1'b1;
            m_ack_o        = s_ack_i[sel_q];
            // a genuine ack wins over a coincident timeout
            m_err_o        = s_err_i[sel_q] | (timeout & !s_ack_i[sel_q]);
            if (m_ack_o || m_err_o) state_n = ST_IDLE;
          end
        end
        ST_DECERR: begin
          m_err_o = m_cyc_i;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // timer reads k in the k-th cycle after acceptance, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel_q <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      if (accept && !no_match) sel_q <= hit;
      if (state != ST_BUSY) timer <= accept ? TW'(1) : '0;
      else if (timer != '1) timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect with a response scoreboard fed at request time.
module tb_wb_interconnect;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]      m_sel_i;
  logic [AW-1:0]   m_adr_i;
  logic [DW-1:0]   m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic            m_ack_o, m_err_o, m_stall_o;
  logic [NS-1:0]   s_cyc_o, s_stb_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]   s_ack_i, s_err_i, s_stall_i;

  int total = 0;
  int bad   = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  wb_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_sel_i   (m_sel_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_stall_o (m_stall_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_stall_i (s_stall_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    s_ack_i = '0; s_err_i = '0; s_stall_i = '0;
  endtask

  task automatic push(input logic ack, input logic err, input logic [31:0] dat);
    resp_t r;
    r.ack = ack; r.err = err; r.dat = dat;
    exp_q.push_back(r);
  endtask

  // Scoreboard: every response the master sees must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (m_ack_o || m_err_o)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {30'd0, m_ack_o, m_err_o}, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("sb_ack", {31'd0, m_ack_o}, {31'd0, e.ack});
        chk("sb_err", {31'd0, m_err_o}, {31'd0, e.err});
        if (e.ack) chk("sb_dat", m_dat_o, e.dat);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    m_sel_i = 4'hF; m_adr_i = 32'h0000_0010; m_dat_i = '0;
    s_dat_i = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    // reset: outputs forced even with a live request and acks
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = '1; s_err_i = '1;
    settle();
    chk("rst_stall", {31'd0, m_stall_o}, 32'd1);
    chk("rst_cyc",   {29'd0, s_cyc_o},  32'd0);
    chk("rst_stb",   {29'd0, s_stb_o},  32'd0);
    chk("rst_ack",   {31'd0, m_ack_o},  32'd0);
    chk("rst_err",   {31'd0, m_err_o},  32'd0);
    chk("rst_dat",   m_dat_o,           32'd0);
    step();
    idle_in(); rst = 1'b0;

    // ROM read, 1-cycle ack
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0000_0010;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    settle();
    chk("rom_stb",   {29'd0, s_stb_o},  32'b001);
    chk("rom_stall", {31'd0, m_stall_o}, 32'd0);
    step();
    m_stb_i = 1'b0; s_ack_i = 3'b001;
    settle();
    chk("rom_stb_off", {29'd0, s_stb_o}, 32'd0);
    chk("rom_cyc",     {29'd0, s_cyc_o}, 32'b001);
    chk("rom_ack",     {31'd0, m_ack_o}, 32'd1);
    chk("rom_dat",     m_dat_o,          32'hDEAD_BEEF);
    step();
    idle_in();
    settle();
    chk("rom_idle_ack", {31'd0, m_ack_o}, 32'd0);
    chk("rom_idle_dat", m_dat_o,          32'd0);

    // SRAM write with 3 stall cycles; a foreign ack during BUSY is ignored
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_sel_i = 4'b0011;
    m_adr_i = 32'h8000_0004; m_dat_i = 32'hCAFE_F00D; s_stall_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sram_stall", {31'd0, m_stall_o}, 32'd1);
      chk("sram_stb_held", {29'd0, s_stb_o}, 32'b010);
      step();
    end
    s_stall_i = '0;
    push(1'b1, 1'b0, 32'h1111_1111);
    settle();
    chk("sram_accept_stall", {31'd0, m_stall_o}, 32'd0);
    chk("sram_sel", {28'd0, s_sel_o}, 32'b0011);
    chk("sram_we",  {31'd0, s_we_o},  32'd1);
    chk("sram_dat", s_dat_o,          32'hCAFE_F00D);
    step();
    m_stb_i = 1'b0; s_ack_i = 3'b001;
    settle();
    chk("sram_foreign_ack", {31'd0, m_ack_o}, 32'd0);
    chk("sram_busy_stall",  {31'd0, m_stall_o}, 32'd1);
    step();
    s_ack_i = 3'b010;
    settle();
    chk("sram_ack", {31'd0, m_ack_o}, 32'd1);
    step();
    idle_in(); m_sel_i = 4'hF;

    // unmapped address: one-cycle error, no strobe
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h4000_0000;
    push(1'b0, 1'b1, 32'd0);
    settle();
    chk("dec_stb",   {29'd0, s_stb_o},  32'd0);
    chk("dec_cyc",   {29'd0, s_cyc_o},  32'd0);
    chk("dec_stall", {31'd0, m_stall_o}, 32'd0);
    step();
    m_stb_i = 1'b0;
    settle();
    chk("dec_err",   {31'd0, m_err_o},  32'd1);
    chk("dec_noack", {31'd0, m_ack_o},  32'd0);
    step();
    settle();
    chk("dec_err_once", {31'd0, m_err_o}, 32'd0);
    step();
    idle_in();

    // CLINT never acks: timeout error in cycle 8 after acceptance
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0200_0008;
    settle();
    chk("clint_stb", {29'd0, s_stb_o}, 32'b100);
    step();
    m_stb_i = 1'b0;
    for (int c = 1; c < 8; c++) begin
      settle();
      chk("clint_wait_err", {31'd0, m_err_o}, 32'd0);
      step();
    end
    push(1'b0, 1'b1, 32'd0);
    settle();
    chk("clint_timeout_err", {31'd0, m_err_o}, 32'd1);
    step();
    s_ack_i = 3'b100;
    settle();
    chk("clint_late_ack", {31'd0, m_ack_o}, 32'd0);
    step();
    idle_in();

    // ROM after timeout; zero-latency ack in the acceptance cycle is ignored
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0000_0020; s_ack_i = 3'b001;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    settle();
    chk("rom2_zero_lat_ack", {31'd0, m_ack_o}, 32'd0);
    step();
    m_stb_i = 1'b0;
    settle();
    chk("rom2_ack", {31'd0, m_ack_o}, 32'd1);
    step();
    idle_in();

    // SRAM abort: cyc dropped before the ack
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h8000_0010;
    step();
    m_stb_i = 1'b0;
    settle();
    chk("abort_cyc_busy", {29'd0, s_cyc_o}, 32'b010);
    step();
    m_cyc_i = 1'b0; s_ack_i = 3'b010;
    settle();
    chk("abort_noack", {31'd0, m_ack_o}, 32'd0);
    chk("abort_cyc",   {29'd0, s_cyc_o}, 32'd0);
    step();
    s_ack_i = '0;
    settle();
    chk("abort_idle_stall", {31'd0, m_stall_o}, 32'd0);
    chk("abort_idle_cyc",   {29'd0, s_cyc_o},  32'd0);

    // reset while BUSY on ROM
    step();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0000_0000;
    step();
    m_stb_i = 1'b0; rst = 1'b1; s_ack_i = 3'b001;
    settle();
    chk("rstbusy_noack", {31'd0, m_ack_o}, 32'd0);
    step();
    settle();
    chk("rstbusy_cyc",   {29'd0, s_cyc_o},  32'd0);
    chk("rstbusy_stb",   {29'd0, s_stb_o},  32'd0);
    chk("rstbusy_stall", {31'd0, m_stall_o}, 32'd1);
    step();
    rst = 1'b0; s_ack_i = '0; m_stb_i = 1'b1;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    settle();
    chk("post_rst_stb",   {29'd0, s_stb_o},  32'b001);
    chk("post_rst_stall", {31'd0, m_stall_o}, 32'd0);
    step();
    m_stb_i = 1'b0; s_ack_i = 3'b001;
    settle();
    chk("post_rst_ack", {31'd0, m_ack_o}, 32'd1);
    step();
    idle_in();
    step();
    step();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
